// File: rtl/me_lsu_pkg.sv
// Shared definitions for the me_lsu memory-access stage: op codes, FSM states
// and load/store classification tables.
package me_lsu_pkg;

    typedef logic [3:0] AluOpBus;

    localparam AluOpBus EX_NOP_OP = 4'd0;
    localparam AluOpBus EX_ADD_OP = 4'd1;
    localparam AluOpBus EX_LB_OP  = 4'd2;
    localparam AluOpBus EX_LH_OP  = 4'd3;
    localparam AluOpBus EX_LW_OP  = 4'd4;
    localparam AluOpBus EX_LBU_OP = 4'd5;
    localparam AluOpBus EX_LHU_OP = 4'd6;
    localparam AluOpBus EX_LWU_OP = 4'd7;
    localparam AluOpBus EX_LD_OP  = 4'd8;
    localparam AluOpBus EX_SB_OP  = 4'd9;
    localparam AluOpBus EX_SH_OP  = 4'd10;
    localparam AluOpBus EX_SW_OP  = 4'd11;
    localparam AluOpBus EX_SD_OP  = 4'd12;

    // One bit per op code; IS_WIDE marks ops that exist only on a 64-bit datapath.
    localparam logic [15:0] IS_LOAD  = 16'h01FC;
    localparam logic [15:0] IS_STORE = 16'h1E00;
    localparam logic [15:0] IS_WIDE  = 16'h1180;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [3:0] access_bytes(input AluOpBus op);
        case (op)
            EX_LB_OP, EX_LBU_OP, EX_SB_OP:            access_bytes = 4'd1;
            EX_LH_OP, EX_LHU_OP, EX_SH_OP:            access_bytes = 4'd2;
            EX_LW_OP, EX_LWU_OP, EX_SW_OP:            access_bytes = 4'd4;
            EX_LD_OP, EX_SD_OP:                       access_bytes = 4'd8;
            default:                                  access_bytes = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/me_lsu_align.sv
// Combinational lane logic shared by the load and store paths: address
// alignment, byte-lane select, write replication and read extraction.
module me_lsu_align
    import me_lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  AluOpBus             op,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W-1:0]   r_data,
    output logic [ADDR_W-1:0]   addr_al,
    output logic [DATA_W/8-1:0] sel,
    output logic [DATA_W-1:0]   w_data_rep,
    output logic [DATA_W-1:0]   r_data_ext,
    output logic                misaligned
);

    localparam int NB = DATA_W / 8;
    localparam int K  = $clog2(NB);

    logic [3:0]              nbytes;
    logic [ADDR_W-1:0]       mask;
    logic [K-1:0]            off;
    logic [NB-1:0]           base;
    logic [DATA_W-1:0]       shifted;
    logic signed [7:0]       b8;
    logic signed [15:0]      h16;
    logic signed [31:0]      w32;
    int                      nb;

    always_comb begin
        nbytes     = access_bytes(op);
        mask       = (nbytes == 4'd0) ? '0 : ADDR_W'(nbytes) - ADDR_W'(1);
        misaligned = |(addr & mask);
        addr_al    = addr & ~mask;
        off        = addr_al[K-1:0];
        nb         = (nbytes == 4'd0) ? 1 : int'(nbytes);

        base = '0;
        for (int i = 0; i < NB; i++) begin
            base[i] = (nbytes != 4'd0) && (i < nb);
        end
        sel = base << off;

        // Narrow store data is repeated across every lane; sel picks the live ones.
        w_data_rep = '0;
        for (int i = 0; i < NB; i++) begin
            w_data_rep[8*i +: 8] = w_data[8*(i % nb) +: 8];
        end

        shifted = r_data >> {off, 3'b000};
        b8      = signed'(shifted[7:0]);
        h16     = signed'(shifted[15:0]);
        w32     = signed'(shifted[31:0]);

        r_data_ext = shifted;
        case (op)
            EX_LB_OP:  r_data_ext = DATA_W'(b8);
            EX_LBU_OP: r_data_ext = DATA_W'(shifted[7:0]);
            EX_LH_OP:  r_data_ext = DATA_W'(h16);
            EX_LHU_OP: r_data_ext = DATA_W'(shifted[15:0]);
            EX_LW_OP:  r_data_ext = DATA_W'(w32);
            EX_LWU_OP: r_data_ext = DATA_W'(shifted[31:0]);
            default:   r_data_ext = shifted;
        endcase
    end

endmodule

// File: rtl/me_lsu.sv
// Memory-access stage between EX and WB: req/ack bus transaction with stall,
// timeout abort and optional misalignment trap (macro LSU_MISALIGN_TRAP_EN).
module me_lsu
    import me_lsu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_enable_i,
    input  logic [REG_ADDR_W-1:0] w_addr_i,
    input  logic [DATA_W-1:0]     w_data_i,
    input  AluOpBus               aluop_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    output logic                  w_enable_o,
    output logic [REG_ADDR_W-1:0] w_addr_o,
    output logic [DATA_W-1:0]     w_data_o,
    output logic                  stall_req_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_W/8-1:0]   mem_sel_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_w_data_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_W-1:0]     mem_r_data_i,
    output logic                  bus_err_o,
    output logic                  misalign_o
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q;
    logic                abort_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                ld_op, st_op, mem_op, trap, start, timeout;
    logic [ADDR_W-1:0]   addr_a;
    logic [DATA_W/8-1:0] sel_a;
    logic [DATA_W-1:0]   wrep_a, rext_a;
    logic                misal_a;

    assign ld_op   = IS_LOAD[aluop_i]  && ((DATA_W == 64) || !IS_WIDE[aluop_i]);
    assign st_op   = IS_STORE[aluop_i] && ((DATA_W == 64) || !IS_WIDE[aluop_i]);
    assign mem_op  = ld_op || st_op;
    assign timeout = (cnt_q == TO_LAST);

    me_lsu_align #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_align (
        .op         (aluop_i),
        .addr       (mem_addr_i),
        .w_data     (w_data_i),
        .r_data     (mem_r_data_i),
        .addr_al    (addr_a),
        .sel        (sel_a),
        .w_data_rep (wrep_a),
        .r_data_ext (rext_a),
        .misaligned (misal_a)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = mem_op && misal_a;
`else
    assign trap = 1'b0;
    logic unused_misal;
    assign unused_misal = misal_a;
`endif

    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        stall_req_o = 1'b0;
        w_enable_o  = w_enable_i;
        w_addr_o    = w_addr_i;
        w_data_o    = w_data_i;
        bus_err_o   = 1'b0;
        misalign_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if (trap) begin
                    w_enable_o = 1'b0;
                    misalign_o = 1'b1;
                end else if (mem_op) begin
                    stall_req_o = 1'b1;
                    w_enable_o  = 1'b0;
                    start       = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                stall_req_o = 1'b1;
                w_enable_o  = 1'b0;
                if (mem_ack_i || timeout) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ld_op) begin
                    w_data_o = rdata_q;
                end
                w_enable_o = w_enable_i && !abort_q;
                bus_err_o  = abort_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Keep every output quiet while reset is held.
        if (rst) begin
            stall_req_o = 1'b0;
            w_enable_o  = 1'b0;
            w_addr_o    = '0;
            w_data_o    = '0;
            bus_err_o   = 1'b0;
            misalign_o  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_sel_o    <= '0;
            mem_addr_o   <= '0;
            mem_w_data_o <= '0;
            cnt_q        <= '0;
            abort_q      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mem_req_o    <= 1'b1;
                        mem_we_o     <= st_op;
                        mem_sel_o    <= sel_a;
                        mem_addr_o   <= addr_a;
                        mem_w_data_o <= st_op ? wrep_a : '0;
                        cnt_q        <= '0;
                        abort_q      <= 1'b0;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 8'd1;
                    // Ack takes priority over a timeout on the same edge.
                    if (mem_ack_i) begin
                        rdata_q   <= rext_a;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                    end else if (timeout) begin
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        abort_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_me_lsu.sv
// Directed bench for me_lsu: a 32-bit instance (TIMEOUT=4) and a 64-bit
// instance driven from one vector table, plus reset-during-transaction sequence.
module tb_me_lsu;
    import me_lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        use64;
    AluOpBus     op;
    logic [31:0] addr;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        ack;
    logic [63:0] rdata;

    AluOpBus op32, op64;
    logic    ack32, ack64;
    assign op32  = use64 ? EX_NOP_OP : op;
    assign op64  = use64 ? op : EX_NOP_OP;
    assign ack32 = !use64 && ack;
    assign ack64 = use64 && ack;

    logic        wen32, stall32, req32, we32, err32, mis32;
    logic [4:0]  wa32;
    logic [31:0] wd32, ba32, bw32;
    logic [3:0]  sel32;
    logic        wen64, stall64, req64, we64, err64, mis64;
    logic [4:0]  wa64;
    logic [63:0] wd64, bw64;
    logic [31:0] ba64;
    logic [7:0]  sel64;

    me_lsu #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT(4)) dut32 (
        .clk(clk), .rst(rst), .w_enable_i(wen), .w_addr_i(waddr), .w_data_i(wdata[31:0]),
        .aluop_i(op32), .mem_addr_i(addr), .w_enable_o(wen32), .w_addr_o(wa32),
        .w_data_o(wd32), .stall_req_o(stall32), .mem_req_o(req32), .mem_we_o(we32),
        .mem_sel_o(sel32), .mem_addr_o(ba32), .mem_w_data_o(bw32), .mem_ack_i(ack32),
        .mem_r_data_i(rdata[31:0]), .bus_err_o(err32), .misalign_o(mis32)
    );

    me_lsu #(.DATA_W(64), .ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT(255)) dut64 (
        .clk(clk), .rst(rst), .w_enable_i(wen), .w_addr_i(waddr), .w_data_i(wdata),
        .aluop_i(op64), .mem_addr_i(addr), .w_enable_o(wen64), .w_addr_o(wa64),
        .w_data_o(wd64), .stall_req_o(stall64), .mem_req_o(req64), .mem_we_o(we64),
        .mem_sel_o(sel64), .mem_addr_o(ba64), .mem_w_data_o(bw64), .mem_ack_i(ack64),
        .mem_r_data_i(rdata), .bus_err_o(err64), .misalign_o(mis64)
    );

    logic        o_wen, o_stall, o_req, o_we, o_err, o_mis;
    logic [4:0]  o_waddr;
    logic [63:0] o_wdata, o_bwdata;
    logic [31:0] o_baddr;
    logic [7:0]  o_sel;

    always_comb begin
        if (use64) begin
            o_wen = wen64; o_stall = stall64; o_req = req64; o_we = we64;
            o_err = err64; o_mis = mis64; o_waddr = wa64; o_wdata = wd64;
            o_bwdata = bw64; o_baddr = ba64; o_sel = sel64;
        end else begin
            o_wen = wen32; o_stall = stall32; o_req = req32; o_we = we32;
            o_err = err32; o_mis = mis32; o_waddr = wa32; o_wdata = {32'h0, wd32};
            o_bwdata = {32'h0, bw32}; o_baddr = ba32; o_sel = {4'h0, sel32};
        end
    end

    typedef struct {
        bit          use64;
        AluOpBus     op;
        logic [31:0] addr;
        bit          wen;
        logic [63:0] wdata;
        int          waits;
        logic [63:0] rdata;
        int          stall;
        bit          chk_data;
        logic [63:0] e_wdata;
        bit          e_wen;
        bit          e_err;
        bit          e_mis;
        logic [7:0]  e_sel;
        logic [63:0] e_bwdata;
        bit          e_we;
        logic [31:0] e_baddr;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit done = 0;
        for (int c = 0; c < 24 && !done; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                use64 = v.use64; op = v.op; addr = v.addr; wen = v.wen;
                wdata = v.wdata; rdata = v.rdata; waddr = 5'(idx + 3);
            end
            ack = (c == v.waits + 1);
            @(negedge clk);
            if (o_stall) begin
                if (c >= 1) check($sformatf("v%0d req_held c%0d", idx, c), 64'(o_req), 64'd1);
                if (c == 1) begin
                    check($sformatf("v%0d mem_sel", idx), 64'(o_sel), 64'(v.e_sel));
                    check($sformatf("v%0d mem_w_data", idx), o_bwdata, v.e_bwdata);
                    check($sformatf("v%0d mem_we", idx), 64'(o_we), 64'(v.e_we));
                    check($sformatf("v%0d mem_addr", idx), 64'(o_baddr), 64'(v.e_baddr));
                end
            end else begin
                done = 1;
                check($sformatf("v%0d stall_cycles", idx), 64'(c), 64'(v.stall));
                check($sformatf("v%0d w_enable", idx), 64'(o_wen), 64'(v.e_wen));
                check($sformatf("v%0d w_addr", idx), 64'(o_waddr), 64'(idx + 3));
                if (v.chk_data) check($sformatf("v%0d w_data", idx), o_wdata, v.e_wdata);
                check($sformatf("v%0d bus_err", idx), 64'(o_err), 64'(v.e_err));
                check($sformatf("v%0d misalign", idx), 64'(o_mis), 64'(v.e_mis));
                check($sformatf("v%0d req_dropped", idx), 64'(o_req), 64'd0);
            end
        end
        ack = 1'b0;
        if (!done) check($sformatf("v%0d done_within_budget", idx), 64'd0, 64'd1);
    endtask

    initial begin
        //           use64 op         addr    wen wdata                  waits rdata                  stall chk e_wdata                e_wen err mis sel    bwdata                 we baddr
        vecs[0]  = '{0, EX_ADD_OP, 32'h000, 1, 64'h1234,              0,  64'h0,                 0, 1, 64'h1234,              1, 0, 0, 8'h00, 64'h0,                 0, 32'h0};
        vecs[1]  = '{0, EX_LB_OP,  32'h103, 1, 64'h0,                 3,  64'h80FF_FFFF,         5, 1, 64'hFFFF_FF80,         1, 0, 0, 8'h08, 64'h0,                 0, 32'h103};
        vecs[2]  = '{0, EX_SH_OP,  32'h202, 0, 64'hBEEF,              2,  64'h0,                 4, 1, 64'hBEEF,              0, 0, 0, 8'h0C, 64'hBEEF_BEEF,         1, 32'h202};
        vecs[3]  = '{0, EX_LHU_OP, 32'h102, 1, 64'h0,                 1,  64'h8001_1234,         3, 1, 64'h8001,              1, 0, 0, 8'h0C, 64'h0,                 0, 32'h102};
        vecs[4]  = '{0, EX_LH_OP,  32'h000, 1, 64'h0,                 0,  64'h0000_F00D,         2, 1, 64'hFFFF_F00D,         1, 0, 0, 8'h03, 64'h0,                 0, 32'h0};
        vecs[5]  = '{0, EX_SB_OP,  32'h001, 0, 64'hA5,                0,  64'h0,                 2, 1, 64'hA5,                0, 0, 0, 8'h02, 64'hA5A5_A5A5,         1, 32'h001};
        vecs[6]  = '{0, EX_SW_OP,  32'h008, 0, 64'hDEAD_BEEF,         0,  64'h0,                 2, 1, 64'hDEAD_BEEF,         0, 0, 0, 8'h0F, 64'hDEAD_BEEF,         1, 32'h008};
        vecs[7]  = '{0, EX_LBU_OP, 32'h102, 1, 64'h0,                 1,  64'h00C3_0000,         3, 1, 64'hC3,                1, 0, 0, 8'h04, 64'h0,                 0, 32'h102};
        vecs[8]  = '{0, EX_LW_OP,  32'h010, 1, 64'h0,                 99, 64'h0,                 5, 0, 64'h0,                 0, 1, 0, 8'h0F, 64'h0,                 0, 32'h010};
        vecs[9]  = '{0, EX_ADD_OP, 32'h000, 1, 64'h55,                0,  64'h0,                 0, 1, 64'h55,                1, 0, 0, 8'h00, 64'h0,                 0, 32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[10] = '{0, EX_LW_OP,  32'h001, 1, 64'h0,                 0,  64'hCAFE_F00D,         0, 0, 64'h0,                 0, 0, 1, 8'h00, 64'h0,                 0, 32'h0};
`else
        vecs[10] = '{0, EX_LW_OP,  32'h001, 1, 64'h0,                 0,  64'hCAFE_F00D,         2, 1, 64'hCAFE_F00D,         1, 0, 0, 8'h0F, 64'h0,                 0, 32'h0};
`endif
        vecs[11] = '{0, EX_ADD_OP, 32'h000, 1, 64'h99,                0,  64'h0,                 0, 1, 64'h99,                1, 0, 0, 8'h00, 64'h0,                 0, 32'h0};
        vecs[12] = '{1, EX_LWU_OP, 32'h004, 1, 64'h0,                 0,  64'h8000_0001_DEAD_BEEF, 2, 1, 64'h0000_0000_8000_0001, 1, 0, 0, 8'hF0, 64'h0,           0, 32'h004};
        vecs[13] = '{1, EX_SD_OP,  32'h008, 0, 64'h0123_4567_89AB_CDEF, 1, 64'h0,                3, 1, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 8'hFF, 64'h0123_4567_89AB_CDEF, 1, 32'h008};
        vecs[14] = '{1, EX_LW_OP,  32'h000, 1, 64'h0,                 0,  64'h1111_2222_8765_4321, 2, 1, 64'hFFFF_FFFF_8765_4321, 1, 0, 0, 8'h0F, 64'h0,           0, 32'h0};
        vecs[15] = '{1, EX_SB_OP,  32'h005, 0, 64'h7E,                0,  64'h0,                 2, 1, 64'h7E,                0, 0, 0, 8'h20, 64'h7E7E_7E7E_7E7E_7E7E, 1, 32'h005};
        vecs[16] = '{1, EX_LD_OP,  32'h010, 1, 64'h0,                 0,  64'hFEDC_BA98_7654_3210, 2, 1, 64'hFEDC_BA98_7654_3210, 1, 0, 0, 8'hFF, 64'h0,           0, 32'h010};
        vecs[17] = '{1, EX_LH_OP,  32'h006, 1, 64'h0,                 0,  64'h8123_0000_0000_0000, 2, 1, 64'hFFFF_FFFF_FFFF_8123, 1, 0, 0, 8'hC0, 64'h0,           0, 32'h006};

        rst = 1'b1; use64 = 1'b0; op = EX_NOP_OP; addr = 32'h0; wen = 1'b1;
        waddr = 5'd7; wdata = 64'h55; ack = 1'b0; rdata = 64'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst stall_req", 64'(o_stall), 64'd0);
        check("rst mem_req", 64'(o_req), 64'd0);
        check("rst mem_sel", 64'(o_sel), 64'd0);
        check("rst mem_addr", 64'(o_baddr), 64'd0);
        check("rst mem_w_data", o_bwdata, 64'd0);
        check("rst w_enable", 64'(o_wen), 64'd0);
        check("rst w_data", o_wdata, 64'd0);
        check("rst bus_err", 64'(o_err), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Reset while a load waits in REQ must abandon the transaction.
        @(posedge clk);
        #1 use64 = 1'b0; op = EX_LW_OP; addr = 32'h20; wen = 1'b1; ack = 1'b0;
        @(posedge clk);
        #1;
        check("rstreq in_req", 64'(o_req), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstreq mem_req", 64'(o_req), 64'd0);
        check("rstreq mem_sel", 64'(o_sel), 64'd0);
        check("rstreq mem_addr", 64'(o_baddr), 64'd0);
        check("rstreq stall_req", 64'(o_stall), 64'd0);
        check("rstreq w_enable", 64'(o_wen), 64'd0);
        check("rstreq bus_err", 64'(o_err), 64'd0);
        rst = 1'b0; op = EX_NOP_OP;
        @(posedge clk);
        #1;
        check("rstreq idle_stall", 64'(o_stall), 64'd0);
        check("rstreq idle_req", 64'(o_req), 64'd0);
        run_vec(vecs[1], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/me_lsu.md
# me_lsu

Parametrised memory-access stage sitting between EX and WB, replacing the single-cycle combinational memory stage. Loads and stores run as a req/ack transaction to a variable-latency data port. The pipeline is stalled through `stall_req_o` until the transaction completes. Adds a 64-bit datapath option, bus timeout and optional misalignment trapping.

## Interface
- `DATA_W`, 32: datapath width, 32 or 64. 64 enables LD/SD/LWU.
- `ADDR_W`, 32: memory address width.
- `REG_ADDR_W`, 5: register-file address width.
- `TIMEOUT`, 255: maximum cycles to wait for `mem_ack_i` before aborting. Range 1..255.
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `w_enable_i`, `w_addr_i[REG_ADDR_W]`, `w_data_i[DATA_W]` in: writeback request from EX. `w_data_i` carries store data for stores.
- `aluop_i` in `AluOpBus`: operation code.
- `mem_addr_i` in `ADDR_W`: effective address.
- `w_enable_o`, `w_addr_o`, `w_data_o` out: writeback request to WB.
- `stall_req_o` out 1: holds IF..EX stages.
- `mem_req_o` out 1: bus request. Registered.
- `mem_we_o` out 1: write strobe.
- `mem_sel_o` out `DATA_W/8`: byte lanes.
- `mem_addr_o` out `ADDR_W`: bus address.
- `mem_w_data_o` out `DATA_W`: bus write data.
- `mem_ack_i` in 1: transaction complete. Read data is valid in the same cycle.
- `mem_r_data_i` in `DATA_W`: read data.
- `bus_err_o` out 1: one-cycle pulse on timeout.
- `misalign_o` out 1: one-cycle pulse on a trapped misaligned access.

## Operation
- Non-memory op in IDLE:
  - Outputs pass through combinationally: `w_*_o = w_*_i`.
  - `stall_req_o = 0`, no bus activity.
- FSM states are IDLE, REQ and DONE.
- IDLE with a memory op:
  - `stall_req_o = 1` combinationally.
  - At the next edge, register the bus address, lanes, replicated write data and `mem_we_o`.
  - Set `mem_req_o = 1`, clear the timeout counter, and go to REQ.
- REQ:
  - `stall_req_o = 1`. Bus outputs are held stable. The counter increments each cycle.
  - At an edge where `mem_ack_i = 1`:
    - Capture the read data. Select the byte, half or word lane by the low address bits and sign- or zero-extend it per op.
    - Drop `mem_req_o` and go to DONE.
  - If the counter reaches `TIMEOUT` without an ack: drop the request, set an abort flag and go to DONE.
  - If ack and timeout coincide, the ack wins.
- DONE:
  - `stall_req_o = 0`.
  - Loads: `w_data_o` = captured data.
  - `w_enable_o = w_enable_i && !abort`.
  - `bus_err_o = abort`.
  - Return to IDLE at the next edge. Upstream advances on the same edge.
- Byte lanes: `addr[k-1:0]` selects lanes, with k=2 for 32-bit and k=3 for 64-bit.
  - SB uses 1 lane and replicates the byte.
  - SH uses 2 lanes; SW uses 4 lanes; SD uses all 8 lanes.
- EX holds `*_i` stable while `stall_req_o` is high. The block does not re-latch its inputs.
- Reset in any state: at that edge go to IDLE, deassert `mem_req_o` immediately, and discard any pending transaction.
- Reset values: every output is 0, including `mem_sel_o`, `mem_addr_o` and `mem_w_data_o`.

## Timing
- Non-memory op: 0 added latency.
- Memory op issued in cycle N:
  - `mem_req_o` is high from N+1.
  - Ack is sampled at edge N+2 at the earliest. DONE is then in N+2, and the pipeline advances at edge N+3.
  - Minimum cost is 2 stall cycles. Each extra wait cycle adds 1.
- Timeout: DONE occurs at most `TIMEOUT + 2` cycles after N.
- `mem_req_o` never glitches. It deasserts exactly one cycle after the ack cycle.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned LH/LHU/SH/LW/LWU/SW/LD/SD in IDLE issues no bus cycle.
  - It pulses `misalign_o` for one cycle with `w_enable_o = 0` and `stall_req_o = 0`. State stays IDLE.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - The low address bits below access size are cleared and the access proceeds normally.
  - `misalign_o` is tied to 0.

## Structure
- Shared package holds:
  - EX_*_OP load/store codes, including new LD/SD/LWU codes.
  - FSM state encodings.
  - `is_load` and `is_store` classification constants.
- One sub-module, `me_lsu_align`, is combinational and shared by the load and store paths:
  - lane select and write-data replication;
  - read extraction and sign/zero extension;
  - misalignment detect.

## Test plan
- ADD result 0x1234 → `w_data_o = 0x1234` in the same cycle; `stall_req_o` and `mem_req_o` stay 0.
- LB at addr 0x103, `DATA_W=32`, ack after 3 wait cycles, read data 0x80FF_FFFF → `w_data_o = 0xFFFF_FF80`. Stall lasts exactly 5 cycles.
- SH at 0x202, data 0xBEEF → `mem_sel_o = 4'b1100`, `mem_w_data_o = 0xBEEF_BEEF`, `mem_we_o = 1`. Request is held until ack.
- `DATA_W=64`, LWU at 0x004, read data 0x8000_0001_xxxx_xxxx → `w_data_o = 0x0000_0000_8000_0001`.
- No ack, `TIMEOUT=4` → `bus_err_o` pulses once, `w_enable_o = 0`, and the block is back in IDLE.
- Misaligned LW at 0x001: with the macro, `misalign_o` pulses and there is no `mem_req_o`. Without the macro, the access goes to 0x000.
- `rst` asserted in REQ → `mem_req_o` and all outputs are 0 at the next edge.
